// File: rtl/control_sequencer.sv
// Hardwired Moore control sequencer: fetch T0-T2, decode/execute T3-T6, HALT on opcode or fetch timeout.
// Optional feature: define CONTROL_SINGLE_STEP_EN to add in_step and the STEP_WAIT state.
module control_sequencer #(
    parameter int FETCH_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        in_reset,
    input  logic [31:0] in_ir,
    input  logic        in_mem_ready,
`ifdef CONTROL_SINGLE_STEP_EN
    input  logic        in_step,
`endif
    output logic        out_reg_clear,
    output logic [3:0]  out_regfile_location,
    output logic [3:0]  out_alu_opcode,
    output logic        out_mdr_select,
    output logic        out_inc_pc,
    output logic        out_regfile_read,
    output logic        out_hi_read,
    output logic        out_lo_read,
    output logic        out_z_hi_read,
    output logic        out_z_lo_read,
    output logic        out_pc_read,
    output logic        out_mdr_read,
    output logic        out_inport_read,
    output logic        out_c_read,
    output logic        out_regfile_write,
    output logic        out_hi_write,
    output logic        out_lo_write,
    output logic        out_z_write,
    output logic        out_pc_write,
    output logic        out_mdr_write,
    output logic        out_ir_write,
    output logic        out_y_write,
    output logic        out_mar_write,
    output logic        out_halted,
    output logic        out_illegal,
    output logic        out_mem_fault
);
    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
`ifdef CONTROL_SINGLE_STEP_EN
        , S_STEP_WAIT
`endif
    } state_t;

    typedef struct packed {
        logic reg_clear, mdr_select, inc_pc, halted;
        logic regfile_read, hi_read, lo_read, z_hi_read, z_lo_read, pc_read, mdr_read, inport_read, c_read;
        logic regfile_write, hi_write, lo_write, z_write, pc_write, mdr_write, ir_write, y_write, mar_write;
    } ctl_t;

    localparam int CNT_W = $clog2(FETCH_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(FETCH_TIMEOUT - 1);
`ifdef CONTROL_SINGLE_STEP_EN
    localparam state_t S_DONE = S_STEP_WAIT;
`else
    localparam state_t S_DONE = S_T0;
`endif

    state_t           state, nxt;
    ctl_t             ctl;
    logic [CNT_W-1:0] wait_cnt;
    logic [4:0]       op;
    logic [3:0]       ra, rb, rc;
    logic             alu, muldiv, known;
    logic             unused_ir_bits;

    assign op             = in_ir[31:27];
    assign ra             = in_ir[26:23];
    assign rb             = in_ir[22:19];
    assign rc             = in_ir[18:15];
    assign unused_ir_bits = ^in_ir[14:0];
    assign alu            = (op >= 5'h03) && (op <= 5'h0C);
    assign muldiv         = (op == 5'h0E) || (op == 5'h0F);
    assign known          = alu || muldiv || (op == 5'h1A) || (op == 5'h1B);

    function automatic ctl_t strobes(state_t s, logic is_alu);
        ctl_t c;
        c = '0;
        case (s)
            S_RESET: c.reg_clear = 1'b1;
            S_T0:    begin c.pc_read = 1'b1; c.mar_write = 1'b1; c.inc_pc = 1'b1; c.pc_write = 1'b1; end
            S_T1:    begin c.mdr_select = 1'b1; c.mdr_write = 1'b1; end
            S_T2:    begin c.mdr_read = 1'b1; c.ir_write = 1'b1; end
            S_T3:    begin c.regfile_read = 1'b1; c.y_write = 1'b1; end
            S_T4:    begin c.regfile_read = 1'b1; c.z_write = 1'b1; end
            S_T5:    begin
                c.z_lo_read     = 1'b1;
                c.regfile_write = is_alu;
                c.lo_write      = !is_alu;
            end
            S_T6:    begin c.z_hi_read = 1'b1; c.hi_write = 1'b1; end
            S_HALT:  c.halted = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        nxt = state;
        case (state)
            S_RESET: nxt = S_T0;
            S_T0:    nxt = S_T1;
            S_T1:    begin
                if (in_mem_ready)            nxt = S_T2;
                else if (wait_cnt == CNT_LIM) nxt = S_HALT;
            end
            S_T2:    nxt = S_T3;
            S_T3:    begin
                if (alu || muldiv)     nxt = S_T4;
                else if (op == 5'h1B)  nxt = S_HALT;
                else                   nxt = S_DONE;
            end
            S_T4:    nxt = S_T5;
            S_T5:    nxt = muldiv ? S_T6 : S_DONE;
            S_T6:    nxt = S_DONE;
            S_HALT:  nxt = S_HALT;
`ifdef CONTROL_SINGLE_STEP_EN
            S_STEP_WAIT: if (in_step) nxt = S_T0;
`endif
            default: nxt = S_RESET;
        endcase
    end

    // Strobes are registered from the next state so they are glitch-free for the whole cycle
    always_ff @(posedge clk) begin
        if (in_reset) begin
            state         <= S_RESET;
            wait_cnt      <= '0;
            ctl           <= strobes(S_RESET, 1'b0);
            out_illegal   <= 1'b0;
            out_mem_fault <= 1'b0;
        end else begin
            state         <= nxt;
            wait_cnt      <= (state == S_T1 && !in_mem_ready) ? wait_cnt + CNT_W'(1) : '0;
            ctl           <= strobes(nxt, alu);
            out_illegal   <= (state == S_T3) && !known;
            out_mem_fault <= (state == S_T1) && !in_mem_ready && (wait_cnt == CNT_LIM);
        end
    end

    // Register selects come from the state plus the IR, which is stable from T3 onward
    always_comb begin
        out_regfile_location = '0;
        out_alu_opcode       = '0;
        case (state)
            S_T3: out_regfile_location = rb;
            S_T4: begin
                out_regfile_location = rc;
                out_alu_opcode       = op[3:0] - 4'd3;
            end
            S_T5: if (alu) out_regfile_location = ra;
            default: ;
        endcase
    end

    assign out_reg_clear     = ctl.reg_clear;
    assign out_mdr_select    = ctl.mdr_select;
    assign out_inc_pc        = ctl.inc_pc;
    assign out_halted        = ctl.halted;
    assign out_regfile_read  = ctl.regfile_read;
    assign out_hi_read       = ctl.hi_read;
    assign out_lo_read       = ctl.lo_read;
    assign out_z_hi_read     = ctl.z_hi_read;
    assign out_z_lo_read     = ctl.z_lo_read;
    assign out_pc_read       = ctl.pc_read;
    assign out_mdr_read      = ctl.mdr_read;
    assign out_inport_read   = ctl.inport_read;
    assign out_c_read        = ctl.c_read;
    assign out_regfile_write = ctl.regfile_write;
    assign out_hi_write      = ctl.hi_write;
    assign out_lo_write      = ctl.lo_write;
    assign out_z_write       = ctl.z_write;
    assign out_pc_write      = ctl.pc_write;
    assign out_mdr_write     = ctl.mdr_write;
    assign out_ir_write      = ctl.ir_write;
    assign out_y_write       = ctl.y_write;
    assign out_mar_write     = ctl.mar_write;
endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: per-cycle expected outputs are queued as stimulus is built, then drained and compared.
module tb_control_sequencer;
    typedef struct packed {
        logic       clr;
        logic [3:0] loc;
        logic [3:0] opc;
        logic       msel;
        logic       inc;
        logic [8:0] rd;   // regfile,hi,lo,z_hi,z_lo,pc,mdr,inport,c
        logic [8:0] wr;   // regfile,hi,lo,z,pc,mdr,ir,y,mar
        logic       halt;
        logic       ill;
        logic       flt;
    } ov_t;

    typedef struct {
        string       name;
        logic        rst;
        logic [31:0] ir;
        logic        ready;
        ov_t         exp;
    } rec_t;

    typedef struct {
        string       name;
        logic [31:0] ir;
        int          waits;
    } vec_t;

    localparam logic [8:0] RD_RF = 9'b100000000, RD_ZHI = 9'b000100000, RD_ZLO = 9'b000010000,
                           RD_PC = 9'b000001000, RD_MDR = 9'b000000100;
    localparam logic [8:0] WR_RF = 9'b100000000, WR_HI = 9'b010000000, WR_LO = 9'b001000000,
                           WR_Z = 9'b000100000, WR_PC = 9'b000010000, WR_MDR = 9'b000001000,
                           WR_IR = 9'b000000100, WR_Y = 9'b000000010, WR_MAR = 9'b000000001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ir = '0;
    logic        ready = 1'b0;
`ifdef CONTROL_SINGLE_STEP_EN
    logic        step = 1'b1;
`endif
    logic        reg_clear, mdr_select, inc_pc, halted, illegal, mem_fault;
    logic [3:0]  location, alu_opcode;
    logic        regfile_read, hi_read, lo_read, z_hi_read, z_lo_read, pc_read, mdr_read, inport_read, c_read;
    logic        regfile_write, hi_write, lo_write, z_write, pc_write, mdr_write, ir_write, y_write, mar_write;
    ov_t         act;

    rec_t q[$];
    logic pend_ill = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    control_sequencer dut (
        .clk(clk), .in_reset(rst), .in_ir(ir), .in_mem_ready(ready),
`ifdef CONTROL_SINGLE_STEP_EN
        .in_step(step),
`endif
        .out_reg_clear(reg_clear), .out_regfile_location(location), .out_alu_opcode(alu_opcode),
        .out_mdr_select(mdr_select), .out_inc_pc(inc_pc),
        .out_regfile_read(regfile_read), .out_hi_read(hi_read), .out_lo_read(lo_read),
        .out_z_hi_read(z_hi_read), .out_z_lo_read(z_lo_read), .out_pc_read(pc_read),
        .out_mdr_read(mdr_read), .out_inport_read(inport_read), .out_c_read(c_read),
        .out_regfile_write(regfile_write), .out_hi_write(hi_write), .out_lo_write(lo_write),
        .out_z_write(z_write), .out_pc_write(pc_write), .out_mdr_write(mdr_write),
        .out_ir_write(ir_write), .out_y_write(y_write), .out_mar_write(mar_write),
        .out_halted(halted), .out_illegal(illegal), .out_mem_fault(mem_fault)
    );

    assign act = {reg_clear, location, alu_opcode, mdr_select, inc_pc,
                  {regfile_read, hi_read, lo_read, z_hi_read, z_lo_read, pc_read, mdr_read, inport_read, c_read},
                  {regfile_write, hi_write, lo_write, z_write, pc_write, mdr_write, ir_write, y_write, mar_write},
                  halted, illegal, mem_fault};

    function automatic ov_t ov(logic [3:0] loc, logic [3:0] opc, logic msel, logic inc,
                               logic [8:0] rd, logic [8:0] wr);
        ov_t o;
        o = '0;
        o.loc = loc; o.opc = opc; o.msel = msel; o.inc = inc; o.rd = rd; o.wr = wr;
        return o;
    endfunction

    function automatic ov_t ov_reset();
        ov_t o;
        o = '0;
        o.clr = 1'b1;
        return o;
    endfunction

    function automatic ov_t ov_halt(logic flt);
        ov_t o;
        o = '0;
        o.halt = 1'b1;
        o.flt = flt;
        return o;
    endfunction

    function automatic logic [31:0] mk_ir(logic [4:0] op, logic [3:0] ra, logic [3:0] rb, logic [3:0] rc);
        return {op, ra, rb, rc, 15'h0};
    endfunction

    task automatic push(string n, logic r, logic [31:0] i, logic rdy, ov_t e);
        rec_t rec;
        e.ill = e.ill | pend_ill;
        pend_ill = 1'b0;
        rec.name = n; rec.rst = r; rec.ir = i; rec.ready = rdy; rec.exp = e;
        q.push_back(rec);
    endtask

    task automatic push_fetch(string n, logic [31:0] i, int waits);
        push({n, ".T0"}, 1'b0, i, 1'b0, ov(4'd0, 4'd0, 1'b0, 1'b1, RD_PC, WR_MAR | WR_PC));
        for (int w = 0; w < waits; w++)
            push({n, ".T1w"}, 1'b0, i, 1'b0, ov(4'd0, 4'd0, 1'b1, 1'b0, 9'd0, WR_MDR));
        push({n, ".T1"}, 1'b0, i, 1'b1, ov(4'd0, 4'd0, 1'b1, 1'b0, 9'd0, WR_MDR));
        push({n, ".T2"}, 1'b0, i, 1'b0, ov(4'd0, 4'd0, 1'b0, 1'b0, RD_MDR, WR_IR));
        push({n, ".T3"}, 1'b0, i, 1'b0, ov(i[22:19], 4'd0, 1'b0, 1'b0, RD_RF, WR_Y));
    endtask

    task automatic push_done(string n, logic [31:0] i);
`ifdef CONTROL_SINGLE_STEP_EN
        push({n, ".SW"}, 1'b0, i, 1'b0, '0);
`endif
    endtask

    task automatic push_reset(string n);
        push({n, ".rst1"}, 1'b1, '0, 1'b0, ov_reset());
        push({n, ".rst2"}, 1'b1, '0, 1'b0, ov_reset());
        push({n, ".rel"}, 1'b0, '0, 1'b0, ov_reset());
    endtask

    task automatic push_instr(string n, logic [31:0] i, int waits);
        logic [4:0] op;
        logic       alu, md;
        op  = i[31:27];
        alu = (op >= 5'h03) && (op <= 5'h0C);
        md  = (op == 5'h0E) || (op == 5'h0F);
        push_fetch(n, i, waits);
        if (alu || md) begin
            push({n, ".T4"}, 1'b0, i, 1'b0, ov(i[18:15], op[3:0] - 4'd3, 1'b0, 1'b0, RD_RF, WR_Z));
            if (alu) begin
                push({n, ".T5"}, 1'b0, i, 1'b0, ov(i[26:23], 4'd0, 1'b0, 1'b0, RD_ZLO, WR_RF));
            end else begin
                push({n, ".T5"}, 1'b0, i, 1'b0, ov(4'd0, 4'd0, 1'b0, 1'b0, RD_ZLO, WR_LO));
                push({n, ".T6"}, 1'b0, i, 1'b0, ov(4'd0, 4'd0, 1'b0, 1'b0, RD_ZHI, WR_HI));
            end
            push_done(n, i);
        end else if (op == 5'h1B) begin
            for (int c = 0; c < 20; c++)
                push({n, ".HALT"}, (c == 19), i, 1'b0, ov_halt(1'b0));
            push_reset(n);
        end else begin
            if (op != 5'h1A) pend_ill = 1'b1;
            push_done(n, i);
        end
    endtask

    task automatic check(string n, ov_t a, ov_t e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
        checks++;
        if (!$onehot0(a.rd)) begin
            errors++;
            $display("FAIL %s.onehot_read: got reads %b expected at most one", n, a.rd);
        end
    endtask

    initial begin
        vec_t vecs[10];
        rec_t r;
        vecs[0] = '{"alu_spec",  32'h4A920000, 0};
        vecs[1] = '{"alu_lo",    mk_ir(5'h03, 4'd1, 4'd7, 4'd9), 2};
        vecs[2] = '{"alu_hi",    mk_ir(5'h0C, 4'd15, 4'd0, 4'd3), 0};
        vecs[3] = '{"mul",       mk_ir(5'h0E, 4'd2, 4'd3, 4'd4), 0};
        vecs[4] = '{"div",       mk_ir(5'h0F, 4'd6, 4'd5, 4'd8), 1};
        vecs[5] = '{"nop",       mk_ir(5'h1A, 4'd1, 4'd2, 4'd3), 0};
        vecs[6] = '{"ill_1f",    mk_ir(5'h1F, 4'd4, 4'd5, 4'd6), 0};
        vecs[7] = '{"ill_0d",    mk_ir(5'h0D, 4'd1, 4'd1, 4'd1), 0};
        vecs[8] = '{"ill_00",    32'h0000_0000, 0};
        vecs[9] = '{"wait14",    mk_ir(5'h05, 4'd9, 4'd10, 4'd11), 14};

        push("por", 1'b1, '0, 1'b0, ov_reset());
        push("por.rel", 1'b0, '0, 1'b0, ov_reset());
        foreach (vecs[k]) push_instr(vecs[k].name, vecs[k].ir, vecs[k].waits);

        // Reset asserted during T4 and held for three edges
        push_fetch("rst_t4", 32'h4A920000, 0);
        push("rst_t4.T4", 1'b1, 32'h4A920000, 1'b0, ov(4'd4, 4'd6, 1'b0, 1'b0, RD_RF, WR_Z));
        push("rst_t4.rst", 1'b1, 32'h4A920000, 1'b0, ov_reset());
        push("rst_t4.rst", 1'b1, 32'h4A920000, 1'b0, ov_reset());
        push("rst_t4.rel", 1'b0, 32'h4A920000, 1'b0, ov_reset());
        push_instr("after_rst", 32'h4A920000, 0);

        // Fetch timeout: fifteen T1 cycles without ready
        push("tmo.T0", 1'b0, '0, 1'b0, ov(4'd0, 4'd0, 1'b0, 1'b1, RD_PC, WR_MAR | WR_PC));
        for (int w = 0; w < 15; w++)
            push("tmo.T1", 1'b0, '0, 1'b0, ov(4'd0, 4'd0, 1'b1, 1'b0, 9'd0, WR_MDR));
        push("tmo.fault", 1'b0, '0, 1'b1, ov_halt(1'b1));
        push("tmo.halt", 1'b0, '0, 1'b1, ov_halt(1'b0));
        push("tmo.halt", 1'b1, '0, 1'b1, ov_halt(1'b0));
        push_reset("tmo");

        push_instr("mul_end", mk_ir(5'h0E, 4'd3, 4'd1, 4'd2), 0);
        push_instr("halt", mk_ir(5'h1B, 4'd0, 4'd0, 4'd0), 0);
        push_instr("final", mk_ir(5'h07, 4'd12, 4'd13, 4'd14), 0);

        repeat (2) @(negedge clk);
        while (q.size() > 0) begin
            r = q.pop_front();
            check(r.name, act, r.exp);
            rst   = r.rst;
            ir    = r.ir;
            ready = r.ready;
            @(negedge clk);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
